// File: rtl/game_pkg.sv
// Shared types and defaults for the tile-map game logic.
package game_pkg;

  localparam int DEF_MAP_W = 16;
  localparam int DEF_MAP_H = 15;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    WATER  = 2'd1,
    GAS    = 2'd2,
    LAVA   = 2'd3
  } terrain_t;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK    = 2'd1,
    COOLDOWN = 2'd2
  } ctrl_state_t;

  // Resolve simultaneous presses to a single step: up > down > left > right.
  function automatic dir_t pick_dir(input logic up, input logic down,
                                    input logic left, input logic right);
    if (up)         return UP;
    else if (down)  return DOWN;
    else if (left)  return LEFT;
    else if (right) return RIGHT;
    else            return NONE;
  endfunction

endpackage

// File: rtl/move_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
module move_timer #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          en_i,
  input  logic [CW-1:0] load_val_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Load wins over decrement; the count parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                    cnt_d = load_val_i;
    else if (en_i && cnt_q != '0)  cnt_d = cnt_q - CW'(1);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/player_move_ctrl.sv
// Player movement sequencer: button -> candidate tile -> terrain query -> commit/reject,
// with a hazard watchdog on the player's own tile between moves.
//  state    | meaning
//  IDLE     | checker points at player; accept a direction request
//  CHECK    | checker points at candidate; commit or reject this cycle
//  COOLDOWN | MOVE_PERIOD cycles with buttons ignored
module player_move_ctrl
  import game_pkg::*;
#(
  parameter int GAME_MAP_WIDTH  = DEF_MAP_W,
  parameter int GAME_MAP_HEIGHT = DEF_MAP_H,
  parameter int START_X         = 0,
  parameter int START_Y         = 0,
  parameter int MOVE_PERIOD     = 4,
  parameter int HAZARD_GRACE    = 8,
  localparam int XW = $clog2(GAME_MAP_WIDTH + 1),
  localparam int YW = $clog2(GAME_MAP_HEIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  output logic [XW-1:0] chk_x,
  output logic [YW-1:0] chk_y,
  input  logic          chk_ok,
  output logic [XW-1:0] player_x,
  output logic [YW-1:0] player_y,
  output logic          moved,
  output logic          blocked,
  output logic          hazard,
  output logic          respawn
);

  localparam int TW = $clog2(MOVE_PERIOD + 1);
  localparam int HW = $clog2(HAZARD_GRACE + 1);

  ctrl_state_t   state_q, state_d;
  logic [XW-1:0] player_x_q, player_x_d, cand_x_q, cand_x_d, next_x;
  logic [YW-1:0] player_y_q, player_y_d, cand_y_q, cand_y_d, next_y;
  logic [HW-1:0] hz_cnt_q, hz_cnt_d;
  logic          moved_q, moved_d, blocked_q, blocked_d;
  logic          respawn_q, respawn_d, hazard_q, hazard_d;
  logic          at_edge, req, hz_eval, hz_fire;
  logic          tmr_load, tmr_en, tmr_done;
  dir_t          dir;

  // Direction decode, edge test before the +-1 so the map never wraps.
  always_comb begin
    dir     = pick_dir(btn_up, btn_down, btn_left, btn_right);
    req     = (dir != NONE);
    at_edge = 1'b0;
    next_x  = player_x_q;
    next_y  = player_y_q;
    unique case (dir)
      UP:    if (player_y_q == '0) at_edge = 1'b1;
             else next_y = player_y_q - YW'(1);
      DOWN:  if (player_y_q == YW'(GAME_MAP_HEIGHT - 1)) at_edge = 1'b1;
             else next_y = player_y_q + YW'(1);
      LEFT:  if (player_x_q == '0) at_edge = 1'b1;
             else next_x = player_x_q - XW'(1);
      RIGHT: if (player_x_q == XW'(GAME_MAP_WIDTH - 1)) at_edge = 1'b1;
             else next_x = player_x_q + XW'(1);
      default: ;
    endcase
    hz_eval = (state_q != CHECK);
    hz_fire = hz_eval && !chk_ok && (hz_cnt_q == HW'(HAZARD_GRACE - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: a respawn always lands in a fresh cooldown.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (hz_fire)  state_d = COOLDOWN;
        else if (req) state_d = at_edge ? COOLDOWN : CHECK;
      end
      CHECK:          state_d = COOLDOWN;
      COOLDOWN: begin
        if (hz_fire)       state_d = COOLDOWN;
        else if (tmr_done) state_d = IDLE;
      end
      default:        state_d = IDLE;
    endcase
  end

  // Outputs: checker address and cooldown timer control.
  always_comb begin
    chk_x    = (state_q == CHECK) ? cand_x_q : player_x_q;
    chk_y    = (state_q == CHECK) ? cand_y_q : player_y_q;
    tmr_load = (state_d == COOLDOWN) && ((state_q != COOLDOWN) || hz_fire);
    tmr_en   = (state_q == COOLDOWN);
  end

  move_timer #(.CW(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .en_i       (tmr_en),
    .load_val_i (TW'(MOVE_PERIOD - 1)),
    .done_o     (tmr_done)
  );

  // Datapath next values: hazard watchdog, candidate latch, commit/reject.
  always_comb begin
    player_x_d = player_x_q;
    player_y_d = player_y_q;
    cand_x_d   = cand_x_q;
    cand_y_d   = cand_y_q;
    hz_cnt_d   = hz_cnt_q;
    hazard_d   = hazard_q;
    moved_d    = 1'b0;
    blocked_d  = 1'b0;
    respawn_d  = 1'b0;
    if (hz_eval) begin
      if (hz_fire) begin
        player_x_d = XW'(START_X);
        player_y_d = YW'(START_Y);
        respawn_d  = 1'b1;
        hz_cnt_d   = '0;
        hazard_d   = 1'b0;
      end else begin
        hazard_d = !chk_ok;
        hz_cnt_d = chk_ok ? '0 : hz_cnt_q + HW'(1);
      end
    end
    if (state_q == IDLE && !hz_fire && req) begin
      if (at_edge) blocked_d = 1'b1;
      else begin
        cand_x_d = next_x;
        cand_y_d = next_y;
      end
    end
    if (state_q == CHECK) begin
      if (chk_ok) begin
        player_x_d = cand_x_q;
        player_y_d = cand_y_q;
        moved_d    = 1'b1;
      end else begin
        blocked_d  = 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      player_x_q <= XW'(START_X);
      player_y_q <= YW'(START_Y);
      cand_x_q   <= '0;
      cand_y_q   <= '0;
      hz_cnt_q   <= '0;
      hazard_q   <= 1'b0;
      moved_q    <= 1'b0;
      blocked_q  <= 1'b0;
      respawn_q  <= 1'b0;
    end else begin
      player_x_q <= player_x_d;
      player_y_q <= player_y_d;
      cand_x_q   <= cand_x_d;
      cand_y_q   <= cand_y_d;
      hz_cnt_q   <= hz_cnt_d;
      hazard_q   <= hazard_d;
      moved_q    <= moved_d;
      blocked_q  <= blocked_d;
      respawn_q  <= respawn_d;
    end
  end

  assign player_x = player_x_q;
  assign player_y = player_y_q;
  assign moved    = moved_q;
  assign blocked  = blocked_q;
  assign respawn  = respawn_q;
  assign hazard   = hazard_q;

endmodule
